// File: rtl/kmeans_reg_file.sv
// kmeans_reg_file
//   Configuration and status register file for the k-means accelerator.
//   It sits between an APB master and the clustering core, and it forwards
//   APB-staged data words to the external 512x91 point RAM.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   paddr/pwrite/psel/
//   penable/pwdata           APB request (zero wait states)
//   prdata, pready           APB response (prdata is combinational)
//   reg_num/reg_write/
//   reg_write_data           core-side register write port
//   interupt, go_core        completion interrupt, core start
//   w_r_ram_n, data2core,
//   address2core,
//   out_en_ram_n,
//   chip_select_ram_n        point RAM write strobe and bus (active-low controls)
//   first/last_ram_address_out,
//   threshold_value          configuration exported to the core
//
// Register map
//   0 internal_status  1 go  2..9 cent_1..cent_8  10 ram_addr  11 ram_data
//   12 first_ram_addr  13 last_ram_addr  14 threshold  (15+ unmapped)

module kmeans_reg_file #(
  parameter int addrWidth    = 9,
  parameter int dataWidth    = 91,
  parameter int reg_amount   = 4,
  parameter int ram_word_len = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addrWidth-1:0]  paddr,
  input  logic                  pwrite,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [dataWidth-1:0]  pwdata,
  output logic [dataWidth-1:0]  prdata,
  output logic                  pready,
  input  logic [reg_amount-1:0] reg_num,
  input  logic                  reg_write,
  input  logic [dataWidth-1:0]  reg_write_data,
  output logic                  interupt,
  output logic                  go_core,
  output logic                  w_r_ram_n,
  output logic [dataWidth-1:0]  data2core,
  output logic [addrWidth-1:0]  address2core,
  output logic                  out_en_ram_n,
  output logic                  chip_select_ram_n,
  output logic [addrWidth-1:0]  first_ram_address_out,
  output logic [addrWidth-1:0]  last_ram_address_out,
  output logic [dataWidth-1:0]  threshold_value
);

  localparam int NumRegs    = 15;
  localparam int StatusIdx  = 0;
  localparam int GoIdx      = 1;
  localparam int RamAddrIdx = 10;
  localparam int RamDataIdx = 11;
  localparam int FirstIdx   = 12;
  localparam int LastIdx    = 13;
  localparam int ThreshIdx  = 14;

  logic [dataWidth-1:0] r_regs [NumRegs];
  logic [dataWidth-1:0] w_next [NumRegs];

  logic                 w_apb_wr;
  logic                 w_core_done;
  logic                 w_ram_wr;
  logic                 r_ram_strobe;
  logic [dataWidth-1:0] r_data2core;
  logic [addrWidth-1:0] r_addr2core;

  assign w_apb_wr    = psel & penable & pwrite;
  assign w_core_done = reg_write && (reg_num == reg_amount'(StatusIdx)) && reg_write_data[0];
  assign w_ram_wr    = w_apb_wr && (paddr == addrWidth'(RamDataIdx));

  // Core writes override a same-cycle APB write; go is owned by APB, and the
  // core can only clear it by reporting completion through internal_status.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      w_next[i] = r_regs[i];
      if (w_apb_wr && (paddr == addrWidth'(i)))
        w_next[i] = pwdata;
      if (reg_write && (reg_num == reg_amount'(i)) && (i != GoIdx))
        w_next[i] = reg_write_data;
    end
    if (w_core_done)
      w_next[GoIdx] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++)
        r_regs[i] <= '0;
      r_ram_strobe <= 1'b0;
      r_data2core  <= '0;
      r_addr2core  <= '0;
    end else begin
      for (int i = 0; i < NumRegs; i++)
        r_regs[i] <= w_next[i];
      r_ram_strobe <= w_ram_wr;
      // Capture the post-write values so the RAM bus shows the word in the
      // cycle right after the APB access edge and then holds it.
      if (w_ram_wr) begin
        r_data2core <= w_next[RamDataIdx];
        r_addr2core <= w_next[RamAddrIdx][addrWidth-1:0];
      end
    end
  end

  always_comb begin
    prdata = '0;
    if (psel && !pwrite && (paddr < addrWidth'(NumRegs)))
      prdata = r_regs[paddr[3:0]];
  end

  assign pready                = 1'b1;
  assign interupt              = r_regs[StatusIdx][0];
  assign go_core               = r_regs[GoIdx][0];
  assign w_r_ram_n             = ~r_ram_strobe;
  assign chip_select_ram_n     = ~r_ram_strobe;
  assign data2core             = r_data2core;
  assign address2core          = r_addr2core;
  // Read enable belongs to the core-side mux; a macro always has positive
  // width, so this stays high.
  assign out_en_ram_n          = (ram_word_len > 0);
  assign first_ram_address_out = r_regs[FirstIdx][addrWidth-1:0];
  assign last_ram_address_out  = r_regs[LastIdx][addrWidth-1:0];
  assign threshold_value       = r_regs[ThreshIdx];

endmodule

// File: tb/tb_kmeans_reg_file.sv
module tb_kmeans_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  paddr;
  logic        pwrite, psel, penable;
  logic [90:0] pwdata, prdata;
  logic        pready;
  logic [3:0]  reg_num;
  logic        reg_write;
  logic [90:0] reg_write_data;
  logic        interupt, go_core, w_r_ram_n, out_en_ram_n, chip_select_ram_n;
  logic [90:0] data2core, threshold_value;
  logic [8:0]  address2core, first_ram_address_out, last_ram_address_out;

  kmeans_reg_file dut (
    .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .reg_num(reg_num), .reg_write(reg_write), .reg_write_data(reg_write_data),
    .interupt(interupt), .go_core(go_core), .w_r_ram_n(w_r_ram_n),
    .data2core(data2core), .address2core(address2core),
    .out_en_ram_n(out_en_ram_n), .chip_select_ram_n(chip_select_ram_n),
    .first_ram_address_out(first_ram_address_out),
    .last_ram_address_out(last_ram_address_out),
    .threshold_value(threshold_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    logic [8:0]  addr;
    logic [90:0] data;
  } ram_exp_t;

  ram_exp_t    ram_q[$];
  logic [90:0] rd_q[$];
  logic [8:0]  mdl_ram_addr = '0;

  task automatic check(input string name, input logic [90:0] act, input logic [90:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: APB read data and RAM write strobes are popped from the scoreboard.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (psel && penable && !pwrite) begin
        if (rd_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL apb_read_unexpected: got read of %0d expected none", paddr);
        end else begin
          check("apb_prdata", prdata, rd_q.pop_front());
        end
      end
      if (w_r_ram_n === 1'b0) begin
        if (ram_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL ram_strobe_unexpected: got strobe at cycle %0d expected none", cyc);
        end else begin
          ram_exp_t e;
          e = ram_q.pop_front();
          check("ram_strobe_cycle", 91'(cyc), 91'(e.cyc));
          check("ram_address2core", 91'(address2core), 91'(e.addr));
          check("ram_data2core", data2core, e.data);
          check("ram_cs_n", 91'(chip_select_ram_n), 91'(0));
          check("ram_oe_n", 91'(out_en_ram_n), 91'(1));
        end
      end else if (ram_q.size() > 0 && ram_q[0].cyc < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL ram_strobe_missing: got none by cycle %0d expected at %0d", cyc, ram_q[0].cyc);
        void'(ram_q.pop_front());
      end
    end
  end

  task automatic apb_write(input logic [8:0] a, input logic [90:0] d);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    if (a == 9'd10) mdl_ram_addr = d[8:0];
    if (a == 9'd11) ram_q.push_back('{cyc + 1, mdl_ram_addr, d});
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [8:0] a, input logic [90:0] exp);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    rd_q.push_back(exp);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic core_write(input logic [3:0] n, input logic [90:0] d);
    @(posedge clk); #1;
    reg_write = 1'b1; reg_num = n; reg_write_data = d;
    @(posedge clk); #1;
    reg_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [99:0] wide;
    logic [90:0] v1;
    wide = {50'h123356, 50'h123456};
    v1   = wide[90:0];

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    reg_num = '0; reg_write = 1'b0; reg_write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_go_core", 91'(go_core), 91'(0));
    check("rst_interupt", 91'(interupt), 91'(0));
    check("rst_w_r_ram_n", 91'(w_r_ram_n), 91'(1));
    check("rst_cs_n", 91'(chip_select_ram_n), 91'(1));
    check("rst_oe_n", 91'(out_en_ram_n), 91'(1));
    check("rst_prdata", prdata, 91'(0));
    check("rst_pready", 91'(pready), 91'(1));
    rst = 1'b0;

    apb_write(9'd10, 91'd1);
    apb_write(9'd11, v1);
    @(posedge clk); #1;
    check("strobe_one_cycle_we", 91'(w_r_ram_n), 91'(1));
    check("strobe_one_cycle_cs", 91'(chip_select_ram_n), 91'(1));
    check("hold_address2core", 91'(address2core), 91'(1));
    check("hold_data2core", data2core, v1);

    apb_write(9'd10, 91'd2);
    apb_write(9'd11, 91'd12);
    apb_read(9'd11, 91'd12);
    check("ram_addr_not_incremented", 91'(address2core), 91'(2));

    apb_write(9'd1, 91'd1);
    check("go_core_set", 91'(go_core), 91'(1));
    core_write(4'd0, 91'd1);
    check("go_core_cleared", 91'(go_core), 91'(0));
    check("interupt_set", 91'(interupt), 91'(1));
    apb_write(9'd0, 91'd0);
    check("interupt_cleared", 91'(interupt), 91'(0));
    core_write(4'd1, 91'd1);
    check("core_go_ignored", 91'(go_core), 91'(0));

    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 9'd4; pwdata = 91'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    reg_write = 1'b1; reg_num = 4'd4; reg_write_data = 91'h55;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; reg_write = 1'b0;
    apb_read(9'd4, 91'h55);

    apb_write(9'd12, 91'd5);
    apb_write(9'd13, 91'd300);
    apb_write(9'd14, 91'd9);
    check("first_ram_address_out", 91'(first_ram_address_out), 91'(5));
    check("last_ram_address_out", 91'(last_ram_address_out), 91'(300));
    check("threshold_value", threshold_value, 91'd9);
    apb_read(9'd13, 91'd300);
    apb_write(9'd20, 91'h123);
    apb_read(9'd20, 91'd0);
    apb_read(9'd15, 91'd0);

    for (int i = 0; i < 20 && (ram_q.size() > 0 || rd_q.size() > 0); i++)
      @(posedge clk);
    #1;
    if (ram_q.size() > 0 || rd_q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: got %0d ram and %0d read entries left expected 0",
               ram_q.size(), rd_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
